// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage plus the IF/ID pipeline register.
//
// This block owns the program counter. It issues word fetches over a
// request/ready handshake with variable latency. It passes each fetched word,
// with its address, to the decode side through the IF/ID register.
//
// When decode stalls while a word is arriving, that word is kept in a
// one-entry hold buffer. Fetching pauses until decode takes it.
//
// A taken branch flushes IF/ID and redirects the PC. If a request is still
// outstanding at that moment, the stage enters a drain state. There it keeps
// the old address on the bus until memory answers, then throws that word
// away.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   imem_req       out  fetch request, held until imem_ready
//   imem_addr      out  fetch word address (bits [1:0] always 00)
//   imem_ready     in   imem_rdata valid this cycle for the current request
//   imem_rdata     in   fetched instruction word
//   stall          in   decode cannot accept; IF/ID holds
//   branch_taken   in   one-cycle flush/redirect pulse
//   branch_target  in   redirect address (bits [1:0] ignored)
//   id_instr       out  IF/ID instruction word (NOP_INSTR when empty)
//   id_pc          out  address of id_instr
//   id_pc_plus8    out  id_pc + 8
//   id_valid       out  id_instr is a real fetched instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus8,
    output logic        id_valid
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic [31:0] drain_addr_q,  drain_addr_d;

    logic        hold_valid_q,  hold_valid_d;
    logic [31:0] hold_instr_q,  hold_instr_d;
    logic [31:0] hold_pc_q,     hold_pc_d;

    logic        id_valid_q,    id_valid_d;
    logic [31:0] id_instr_q,    id_instr_d;
    logic [31:0] id_pc_q,       id_pc_d;
    logic [31:0] id_pc_plus8_q, id_pc_plus8_d;

    // Masking keeps every target bit in use while forcing word alignment.
    logic [31:0] target_aligned;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;

    assign target_aligned = branch_target & ~32'h0000_0003;
    assign pc_plus4       = pc_q + 32'd4;
    assign pc_plus8       = pc_q + 32'd8;

    // ------------------------------------------------------------------
    // Next-state and IF/ID update
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drain_addr_d  = drain_addr_q;
        hold_valid_d  = hold_valid_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus8_d = id_pc_plus8_q;

        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    if (branch_taken) begin
                        // The word just returned lies on the wrong path.
                        pc_d       = target_aligned;
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                    end else if (stall && id_valid_q) begin
                        // Decode is full: park the word and stop requesting.
                        hold_valid_d = 1'b1;
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pc_q;
                        pc_d         = pc_plus4;
                        state_d      = ST_HOLD;
                    end else begin
                        // An empty slot accepts the word even under stall.
                        id_valid_d    = 1'b1;
                        id_instr_d    = imem_rdata;
                        id_pc_d       = pc_q;
                        id_pc_plus8_d = pc_plus8;
                        pc_d          = pc_plus4;
                    end
                end else begin
                    if (branch_taken) begin
                        // The request cannot be withdrawn. Remember its
                        // address so it can be completed and discarded.
                        drain_addr_d = pc_q;
                        pc_d         = target_aligned;
                        id_valid_d   = 1'b0;
                        id_instr_d   = NOP_INSTR;
                        state_d      = ST_DRAIN;
                    end else if (!stall) begin
                        // Decode consumed the slot and nothing replaces it.
                        id_valid_d = 1'b0;
                        id_instr_d = NOP_INSTR;
                    end
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    hold_valid_d = 1'b0;
                    pc_d         = target_aligned;
                    id_valid_d   = 1'b0;
                    id_instr_d   = NOP_INSTR;
                    state_d      = ST_FETCH;
                end else if (!stall) begin
                    hold_valid_d  = 1'b0;
                    id_valid_d    = 1'b1;
                    id_instr_d    = hold_instr_q;
                    id_pc_d       = hold_pc_q;
                    id_pc_plus8_d = hold_pc_q + 32'd8;
                    state_d       = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                // IF/ID was cleared on entry. A later branch only retargets.
                if (branch_taken) begin
                    pc_d       = target_aligned;
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end
                if (imem_ready) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_FETCH;
            pc_q          <= RESET_PC;
            drain_addr_q  <= RESET_PC;
            hold_valid_q  <= 1'b0;
            hold_instr_q  <= NOP_INSTR;
            hold_pc_q     <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= RESET_PC;
            id_pc_plus8_q <= RESET_PC + 32'd8;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drain_addr_q  <= drain_addr_d;
            hold_valid_q  <= hold_valid_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus8_q <= id_pc_plus8_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The state register does not clear until the reset edge, so the
    // request is also gated directly by reset.
    assign imem_req    = !reset && (state_q != ST_HOLD);
    assign imem_addr   = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus8 = id_pc_plus8_q;
    assign id_valid    = id_valid_q;

endmodule
